// File: rtl/pc_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen_pkg
// Purpose  : Shared constants, state encoding and helper functions for the
//            program-counter generator (pc_gen) and its redirect arbiter.
// Contents : c_RESET_VEC_DEF / c_EXC_VEC_DEF  default vector addresses
//            pc_state_e                       {PC_ST_RUN, PC_ST_HOLD}
//            f_seq_next                       next fetch-group address
//            f_inst_num                       valid slots left in a group
// Revision : 1.0  initial release
// ============================================================================
package pc_gen_pkg;

    // Default vector addresses (MIPS-style boot ROM / general exception entry)
    localparam logic [31:0] c_RESET_VEC_DEF = 32'hbfc00000;
    localparam logic [31:0] c_EXC_VEC_DEF   = 32'hbfc00380;

    // RUN : pc drives inst_addr
    // HOLD: a redirect target is parked in pend_pc behind an unaccepted request
    typedef enum logic [0:0] {
        PC_ST_RUN  = 1'b0,
        PC_ST_HOLD = 1'b1
    } pc_state_e;

    // Start of the next fetch group: clear the in-group offset, step one group.
    // grp_bytes is a power of two; the add wraps modulo 2^32 naturally.
    function automatic logic [31:0] f_seq_next(input logic [31:0] pc,
                                               input logic [31:0] grp_bytes);
        return (pc & ~(grp_bytes - 32'd1)) + grp_bytes;
    endfunction

    // Instructions remaining in the group from pc to the group boundary.
    function automatic logic [2:0] f_inst_num(input logic [31:0] pc,
                                              input int unsigned fetch_w);
        logic [31:0] off;
        off = (pc & ((fetch_w << 2) - 32'd1)) >> 2;
        return 3'(fetch_w - off);
    endfunction

endpackage : pc_gen_pkg
`default_nettype wire

// File: rtl/pc_redirect_arb.sv
`default_nettype none
// ============================================================================
// Module   : pc_redirect_arb
// Purpose  : Combinational priority select of the redirect sources.
//            exception > eret > br_take; only the winner's target is output.
// Ports    : i_exception          exception pulse (target EXC_VEC)
//            i_eret / i_epc       exception-return pulse and its target
//            i_br_take/i_br_target branch pulse and its target
//            o_vld                any redirect requested this cycle
//            o_tgt                target of the highest-priority redirect
// Revision : 1.0  initial release
// ============================================================================
module pc_redirect_arb
    import pc_gen_pkg::*;
#(
    parameter logic [31:0] EXC_VEC = c_EXC_VEC_DEF
) (
    input  logic        i_exception,
    input  logic        i_eret,
    input  logic [31:0] i_epc,
    input  logic        i_br_take,
    input  logic [31:0] i_br_target,
    output logic        o_vld,
    output logic [31:0] o_tgt
);

    always_comb begin
        o_vld = i_exception | i_eret | i_br_take;
        if (i_exception) begin
            o_tgt = EXC_VEC;
        end else if (i_eret) begin
            o_tgt = i_epc;
        end else if (i_br_take) begin
            o_tgt = i_br_target;
        end else begin
            o_tgt = 32'd0;
        end
    end

endmodule : pc_redirect_arb
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen
// Purpose  : Instruction-fetch program-counter generator with valid/ready
//            style request handshake, prioritised redirects and optional
//            misaligned-target detection.
// Params   : RESET_VEC  first fetch address after reset
//            EXC_VEC    exception entry address
//            FETCH_W    instructions per fetch group (1, 2 or 4)
// Ports    : clk, resetn (sync, active-low)
//            stall                 downstream cannot take a new fetch
//            exception/eret/br_take one-cycle redirect pulses
//            epc, br_target        redirect targets
//            inst_req/inst_addr/inst_num  fetch request, held until accepted
//            inst_addr_ok          memory accepts the request this cycle
//            fetch_adel            misaligned redirect target flag
// Config   : PC_ALIGN_CHECK_EN -- when defined, a misaligned redirect target
//            raises fetch_adel for one cycle and halts fetching until the next
//            redirect; when undefined, target bits [1:0] are dropped and
//            fetch_adel is tied low.
// Revision : 1.0  initial release
// ============================================================================
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = c_RESET_VEC_DEF,
    parameter logic [31:0] EXC_VEC   = c_EXC_VEC_DEF,
    parameter int unsigned FETCH_W   = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall,
    input  logic        exception,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        br_take,
    input  logic [31:0] br_target,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    output logic [2:0]  inst_num,
    input  logic        inst_addr_ok,
    output logic        fetch_adel
);

    localparam logic [0:0]  c_ST_RUN    = PC_ST_RUN;
    localparam logic [0:0]  c_ST_HOLD   = PC_ST_HOLD;
    localparam logic [31:0] c_GRP_BYTES = 32'(4 * FETCH_W);

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_pend_pc;
    logic [31:0] w_pend_nxt;
    logic        r_busy;        // request presented last cycle, not accepted

    logic        w_redir_vld;
    logic [31:0] w_redir_raw;
    logic [31:0] w_redir_tgt;
    logic        w_fire;
    logic        w_blocked;     // request presented this cycle, not accepted
    logic        w_load_vld;    // pc takes a new non-sequential/seq value
    logic [31:0] w_load_tgt;
    logic        w_tgt_bad;     // load target rejected as misaligned
    logic        w_halt;        // fetching stopped after a rejected target

    // ------------------------------------------------------------------
    // Redirect source selection
    // ------------------------------------------------------------------
    pc_redirect_arb #(
        .EXC_VEC     (EXC_VEC)
    ) u_arb (
        .i_exception (exception),
        .i_eret      (eret),
        .i_epc       (epc),
        .i_br_take   (br_take),
        .i_br_target (br_target),
        .o_vld       (w_redir_vld),
        .o_tgt       (w_redir_raw)
    );

`ifdef PC_ALIGN_CHECK_EN
    // Keep the raw low bits so a misaligned target can be detected on load.
    assign w_redir_tgt = w_redir_raw;
`else
    assign w_redir_tgt = w_redir_raw & ~32'h3;
`endif

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // An accepted-pending request (r_busy) overrides stall so that a request
    // is never withdrawn once shown. resetn gates the output directly so
    // no request is shown while reset is held.
    assign inst_req  = resetn & ~w_halt & (~stall | r_busy);
    assign w_fire    = inst_req & inst_addr_ok;
    assign w_blocked = inst_req & ~inst_addr_ok;
    assign inst_addr = r_pc & ~32'h3;

    // ------------------------------------------------------------------
    // Next-pc / state selection
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend_pc;
        w_load_vld  = 1'b0;
        w_load_tgt  = r_pc;

        if (w_redir_vld) begin
            if (w_blocked) begin
                // Current address must stay on the bus: park the target.
                // In HOLD this simply replaces the older pending target.
                w_pend_nxt  = w_redir_tgt;
                w_state_nxt = c_ST_HOLD;
            end else begin
                // Nothing outstanding, or the request fires now: the newest
                // redirect wins over any parked target.
                w_load_vld  = 1'b1;
                w_load_tgt  = w_redir_tgt;
                w_state_nxt = c_ST_RUN;
            end
        end else if (w_fire) begin
            w_load_vld  = 1'b1;
            w_load_tgt  = (r_state == c_ST_HOLD) ? r_pend_pc
                                                 : f_seq_next(r_pc, c_GRP_BYTES);
            w_state_nxt = c_ST_RUN;
        end

        w_pc_nxt = (w_load_vld && !w_tgt_bad) ? w_load_tgt : r_pc;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= c_ST_RUN;
            r_pc      <= RESET_VEC;
            r_pend_pc <= 32'd0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_pend_pc <= w_pend_nxt;
            r_busy    <= w_blocked;
        end
    end

    // ------------------------------------------------------------------
    // Misaligned-target handling
    // ------------------------------------------------------------------
`ifdef PC_ALIGN_CHECK_EN
    logic r_halt;
    logic r_adel;

    // Sequential group steps are always aligned; only redirect targets
    // (direct or parked in pend_pc) can be misaligned.
    assign w_tgt_bad = w_load_vld & (w_load_tgt[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_halt <= 1'b0;
            r_adel <= 1'b0;
        end else begin
            // Flag is raised in the cycle the bad target would have appeared.
            r_adel <= w_tgt_bad;
            if (w_load_vld) begin
                r_halt <= w_tgt_bad;
            end
        end
    end

    assign w_halt     = r_halt;
    assign fetch_adel = r_adel;
`else
    assign w_tgt_bad  = 1'b0;
    assign w_halt     = 1'b0;
    assign fetch_adel = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Group occupancy
    // ------------------------------------------------------------------
    generate
        if (FETCH_W == 1) begin : g_num_single
            assign inst_num = 3'd1;
        end else begin : g_num_group
            assign inst_num = f_inst_num(r_pc, FETCH_W);
        end
    endgenerate

endmodule : pc_gen
`default_nettype wire
